// File: rtl/dma_push_ctrl.sv
// Source-side push controller for one DMA channel: walks a byte-granular
// descriptor as word-aligned single-beat reads and pushes each word with a byte mask.
module dma_push_ctrl #(
  parameter int DATA_WD = 32,
  parameter int BE_WD   = DATA_WD / 8,
  parameter int ADDR_WD = 32,
  parameter int LEN_WD  = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic [ADDR_WD-1:0] src_addr_i,
  input  logic [LEN_WD-1:0]  len_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               rd_req_o,
  output logic [ADDR_WD-1:0] rd_addr_o,
  input  logic               rd_gnt_i,
  input  logic               rd_rvalid_i,
  input  logic [DATA_WD-1:0] rd_rdata_i,
  output logic               wvalid_o,
  output logic [DATA_WD-1:0] wdata_o,
  output logic [BE_WD-1:0]   wbe_o,
  input  logic               wready_i
);

  localparam int OFF_WD = $clog2(BE_WD);
  localparam int CNT_WD = OFF_WD + 1;
  localparam logic [CNT_WD-1:0] BE_CNT = CNT_WD'(BE_WD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_WD-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WD-1:0]  remain_q, remain_d;
  logic [DATA_WD-1:0] data_q, data_d;
  logic [BE_WD-1:0]   be_q, be_d;

  logic [OFF_WD-1:0]  off;
  logic [CNT_WD-1:0]  room;
  logic [CNT_WD-1:0]  nbytes;
  logic [BE_WD-1:0]   be_calc;
  logic [LEN_WD-1:0]  remain_next;
  logic               fire;

  // Bytes of the current word that belong to the transfer: from the address
  // offset up to either the end of the word or the end of the transfer.
  always_comb begin
    off         = cur_addr_q[OFF_WD-1:0];
    room        = BE_CNT - CNT_WD'(off);
    nbytes      = (remain_q < LEN_WD'(room)) ? CNT_WD'(remain_q) : room;
    remain_next = remain_q - LEN_WD'(nbytes);
  end

  always_comb begin
    be_calc = '0;
    for (int i = 0; i < BE_WD; i++) begin
      be_calc[i] = (CNT_WD'(i) >= CNT_WD'(off)) &&
                   (CNT_WD'(i) <  CNT_WD'(off) + nbytes);
    end
  end

  assign fire = (state_q == S_PUSH) && wready_i;

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    data_d     = data_q;
    be_d       = be_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            cur_addr_d = src_addr_i;
            remain_d   = len_i;
            state_d    = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (rd_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_rvalid_i) begin
          data_d  = rd_rdata_i;
          be_d    = be_calc;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if (fire) begin
          cur_addr_d = cur_addr_q + ADDR_WD'(nbytes);
          remain_d   = remain_next;
          state_d    = (remain_next == '0) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      data_q     <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      data_q     <= data_d;
      be_q       <= be_d;
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign rd_req_o  = (state_q == S_REQ);
  assign rd_addr_o = {cur_addr_q[ADDR_WD-1:OFF_WD], {OFF_WD{1'b0}}};
  assign wvalid_o  = (state_q == S_PUSH);
  assign wdata_o   = data_q;
  assign wbe_o     = be_q;

endmodule

// File: doc/dma_push_ctrl.md
# dma_push_ctrl

Source-side push controller for one DMA channel. It takes a byte-granular transfer descriptor (source address, byte length) and issues word-aligned single-beat reads on the source read port. Each returned word is pushed into the channel byte buffer with a contiguous byte-enable mask covering only the bytes belonging to the transfer. It sits directly upstream of the channel buffer and drives that buffer's `wvalid`/`wdata`/`wbe`/`wready` write interface.

## Interface
- `DATA_WD`, 32, data width in bits (multiple of 8).
- `BE_WD`, `DATA_WD/8`, byte-enable width.
- `ADDR_WD`, 32, address width.
- `LEN_WD`, 16, byte-length width.
- Localparam `OFF_WD` = `$clog2(BE_WD)`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `src_addr_i`  in  ADDR_WD  first source byte address; any alignment.
- `len_i`  in  LEN_WD  transfer length in bytes.
- `busy_o`  out  1  high whenever state != IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `rd_req_o`  out  1  source read request.
- `rd_addr_o`  out  ADDR_WD  word-aligned read address; low OFF_WD bits are always 0.
- `rd_gnt_i`  in  1  request accepted when asserted with `rd_req_o`.
- `rd_rvalid_i`  in  1  read data valid.
- `rd_rdata_i`  in  DATA_WD  read data.
- `wvalid_o`  out  1  push valid to buffer.
- `wdata_o`  out  DATA_WD  word as read; unshifted.
- `wbe_o`  out  BE_WD  contiguous byte-enable mask.
- `wready_i`  in  1  buffer ready; a push fires on `wvalid_o && wready_i`.

## Operation
- Registers:
  - `cur_addr` (ADDR_WD), `remain` (LEN_WD), `data_q`, `be_q`.
  - FSM states: IDLE, REQ, WAIT, PUSH, DONE.
- IDLE
  - `start_i && len_i!=0`: latch `cur_addr<=src_addr_i` and `remain<=len_i`, go to REQ.
  - `start_i && len_i==0`: go to DONE; no read is issued.
- REQ
  - `rd_req_o=1`, `rd_addr_o={cur_addr[ADDR_WD-1:OFF_WD],0}`.
  - `rd_gnt_i` moves the FSM to WAIT. Request and address hold until granted.
- WAIT
  - On `rd_rvalid_i`: capture `data_q<=rd_rdata_i` and compute `be_q`, then go to PUSH.
- PUSH
  - `wvalid_o=1`; `wdata_o=data_q`, `wbe_o=be_q`, all held stable until fire.
  - On fire: `cur_addr += nbytes`, `remain -= nbytes`.
  - Next state: DONE if the new `remain==0`, otherwise REQ.
- DONE
  - `done_o=1` for exactly one cycle, then go to IDLE.
- Byte-enable arithmetic:
  - `off = cur_addr[OFF_WD-1:0]`
  - `room = BE_WD - off` (OFF_WD+1 bits)
  - `nbytes = (remain < room) ? remain : room` (OFF_WD+1 bits, range 1..BE_WD)
  - `be = ((1<<nbytes)-1) << off`, truncated to BE_WD; always one contiguous run of ones.
- Only one read is outstanding at a time. There is no pipelining across words.
- `start_i` outside IDLE is ignored.
- `rd_rvalid_i` outside WAIT is ignored, and its data is discarded.
- `cur_addr` wraps modulo 2^ADDR_WD.
- `remain` never underflows, because `nbytes <= remain`.

## Timing
- Reset (`rstn_i` low at a clock edge):
  - State returns to IDLE on that edge.
  - All outputs are 0: `busy_o`, `done_o`, `rd_req_o`, `rd_addr_o`, `wvalid_o`, `wdata_o`, `wbe_o`.
  - Internal registers are cleared.
- Reset mid-transfer aborts the transfer with no `done_o`. Late `rd_rvalid_i` is ignored.
- `start_i` accepted at edge N: `rd_req_o` and `busy_o` are high in cycle N+1.
- Per word, the minimum is 3 cycles:
  - REQ for 1 cycle when `rd_gnt_i` is already high.
  - WAIT for at least 1 cycle; data is captured on the `rd_rvalid_i` edge.
  - PUSH for at least 1 cycle.
- `rd_rvalid_i` in the same cycle as the grant is not sampled. Data is only sampled in WAIT.
- The last push fires at edge M: `done_o` is high in cycle M+1 and `busy_o` is low in cycle M+2.
- Zero-length start at edge N: `done_o` is high in cycle N+1.
- The buffer deasserts `wready_i` for several cycles after each accepted word. The block must tolerate an arbitrary `wready_i` low time and holds PUSH throughout.

## Test plan
- Aligned transfer: `src_addr=0x100`, `len=8`, grant and data immediate.
  - Expect reads at 0x100 and 0x104, each push with `wbe=4'b1111`, one `done_o`, and 6 cycles from the first `rd_req_o` to the last fire.
- Unaligned both ends: `src_addr=0x101`, `len=6`.
  - Expect read 0x100 pushed with `wbe=4'b1110`, then read 0x104 pushed with `wbe=4'b0111`, then `done_o`.
- Sub-word transfer: `src_addr=0x202`, `len=1`.
  - Expect a single read at 0x200, push with `wbe=4'b0100`, and `wdata_o` equal to the raw read word.
- Backpressure and grant stall: hold `rd_gnt_i` low for 4 cycles and `wready_i` low for 5 cycles in PUSH.
  - Expect `rd_addr_o` stable during the grant stall.
  - Expect `wvalid_o`, `wdata_o`, `wbe_o` stable during the `wready_i` stall.
  - Expect no new `rd_req_o` until the push fires.
- Zero length and ignored start: `len=0`.
  - Expect no `rd_req_o` and `done_o` in the next cycle.
  - A `start_i` pulse while busy changes neither `cur_addr` nor the count of issued reads.
- Reset mid-transfer: drive `rstn_i` low in WAIT, then pulse `rd_rvalid_i` after reset releases.
  - Expect all outputs 0, no push, and no `done_o`.
  - A following `start_i` with `addr=0x0`, `len=4` completes normally with `wbe=4'b1111`.
